// File: rtl/fft_stream_driver_if.sv
// Stream bundle between the host driver and the stream accumulator engine.
// master: driver side (sends samples, receives result); slave: engine side.
interface fft_stream_driver_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  m00_axis_tvalid;
   logic [DATA_WIDTH-1:0] m00_axis_tdata;
   logic                  m00_axis_tlast;
   logic                  m00_axis_tready;
   logic                  s00_axis_tvalid;
   logic [DATA_WIDTH-1:0] s00_axis_tdata;
   logic                  s00_axis_tlast;
   logic                  s00_axis_tready;

   modport master (
      output m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast,
      input  m00_axis_tready,
      input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
      output s00_axis_tready
   );

   modport slave (
      input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast,
      output m00_axis_tready,
      output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
      input  s00_axis_tready
   );
endinterface

// File: rtl/fft_stream_driver.sv
// Host-side frame driver: buffers SIZE words, streams them out with tlast,
// pulses start, then captures one result word for the host.
// Ports: s00_axi_aclk/s00_axi_aresetn (async active-low), wr_en/wr_addr/
// wr_data buffer write, go launch, axis (stream bundle, master side),
// start engine trigger, result/result_valid/busy/timeout status.
// Option: define FFT_DRV_TIMEOUT_EN to bound the result wait.
module fft_stream_driver #(
   parameter int SIZE           = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  go,
   fft_stream_driver_if.master   axis,
   output logic                  start,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid,
   output logic                  busy,
   output logic                  timeout
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] KICK = 2'd2;
   localparam logic [1:0] WAIT = 2'd3;

   localparam logic [ADDR_WIDTH:0]   SIZE_X = (ADDR_WIDTH+1)'(SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0] mem [SIZE];

   logic idle;
   logic send;
   logic wr_ok;
   logic beat;
   logic res_hs;
   logic tmo_hit;

   assign idle   = (state == IDLE);
   assign send   = (state == SEND);
   assign wr_ok  = idle && wr_en && ({1'b0, wr_addr} < SIZE_X);
   assign beat   = send && axis.m00_axis_tready;
   assign res_hs = (state == WAIT) && axis.s00_axis_tvalid;

   // Buffer is deliberately not reset so contents survive a reset.
   always_ff @(posedge s00_axi_aclk) begin
      if (wr_ok)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state        <= IDLE;
         rd_ptr       <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  result_valid <= 1'b0;
                  rd_ptr       <= '0;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (beat) begin
                  if (rd_ptr == LAST)
                     state <= KICK;
                  else
                     rd_ptr <= rd_ptr + 1'b1;
               end
            end
            KICK: state <= WAIT;
            WAIT: begin
               if (res_hs) begin
                  result       <= axis.s00_axis_tdata;
                  result_valid <= 1'b1;
                  state        <= IDLE;
               end else if (tmo_hit) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FFT_DRV_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt;
   logic          timeout_q;

   // A result arriving on the limit cycle takes priority over expiry.
   assign tmo_hit = (state == WAIT) && !axis.s00_axis_tvalid
                    && (wait_cnt == LIMIT);

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == KICK)
            wait_cnt <= '0;
         else if ((state == WAIT) && !axis.s00_axis_tvalid)
            wait_cnt <= wait_cnt + 1'b1;

         if (idle && go)
            timeout_q <= 1'b0;
         else if (tmo_hit)
            timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES == 0);
   assign tmo_hit    = 1'b0;
   assign timeout    = 1'b0;
`endif

   // Result tlast is accepted but carries no meaning for a single word.
   logic unused_last;
   assign unused_last = axis.s00_axis_tlast;

   // Data/last are gated so the link reads all-zero outside SEND.
   assign axis.m00_axis_tvalid = send;
   assign axis.m00_axis_tdata  = send ? mem[rd_ptr] : '0;
   assign axis.m00_axis_tlast  = send && (rd_ptr == LAST);
   assign axis.s00_axis_tready = (state == WAIT);
   assign start                = (state == KICK);
   assign busy                 = !idle;

endmodule

// File: tb/tb_fft_stream_driver.sv
// Self-checking bench for fft_stream_driver against a frame-level model.
// Define FFT_DRV_TIMEOUT_EN to also exercise the result wait limit.
module tb_fft_stream_driver;

   localparam int SZ = 10;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        go;
   logic        start;
   logic [31:0] result;
   logic        result_valid;
   logic        busy;
   logic        timeout;

   int n_cmp;
   int n_bad;

   logic [31:0] model [SZ];

   fft_stream_driver_if #(.DATA_WIDTH(32)) axis ();

   fft_stream_driver #(
      .SIZE(SZ), .DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .s00_axi_aclk(clk),
      .s00_axi_aresetn(rst_n),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .go(go),
      .axis(axis.master),
      .start(start),
      .result(result),
      .result_valid(result_valid),
      .busy(busy),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write_word(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (a < SZ)
         model[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      logic [37:0] got;
      got = {axis.m00_axis_tvalid, axis.m00_axis_tlast,
             axis.s00_axis_tready, start, busy, timeout};
      n_cmp++;
      if (got[5:0] !== 6'b0) begin
         n_bad++;
         $display("FAIL %s_ctrl: got %b want 000000", tag, got[5:0]);
      end
      n_cmp++;
      if (axis.m00_axis_tdata !== 32'h0) begin
         n_bad++;
         $display("FAIL %s_tdata: got %h want 0", tag, axis.m00_axis_tdata);
      end
      n_cmp++;
      if ({result_valid, result} !== 33'h0) begin
         n_bad++;
         $display("FAIL %s_result: got %b/%h want 0/0", tag,
                  result_valid, result);
      end
   endtask

   // mode 0: tready held 1; 1: toggling 1,0; 2: random.
   task automatic run_frame(input int mode, input logic [31:0] rv,
                            input bit early, input bit poke, input bit give);
      int cyc;
      int idx;
      int d;
      bit pstall;
      logic [31:0] ptd;
      logic ptl;
      @(negedge clk);
      go = 1'b1;
      axis.m00_axis_tready = 1'b1;
      axis.s00_axis_tvalid = early;
      axis.s00_axis_tdata  = rv;
      axis.s00_axis_tlast  = 1'b1;
      @(negedge clk);
      go  = 1'b0;
      cyc = 1;
      n_cmp++;
      if ({axis.m00_axis_tvalid, busy, result_valid, timeout} !== 4'b1100) begin
         n_bad++;
         $display("FAIL go_entry: got v/b/rv/to=%b want 1100",
                  {axis.m00_axis_tvalid, busy, result_valid, timeout});
      end
      idx    = 0;
      pstall = 1'b0;
      ptd    = '0;
      ptl    = 1'b0;
      while (idx < SZ && cyc < 200) begin
         case (mode)
            0: axis.m00_axis_tready = 1'b1;
            1: axis.m00_axis_tready = (cyc % 2 == 1);
            default: axis.m00_axis_tready = 1'($urandom % 2);
         endcase
         go    = poke && (cyc == 3);
         wr_en = poke && (cyc == 3);
         wr_addr = 4'd0;
         wr_data = ~model[0];
         if (early) begin
            n_cmp++;
            if (axis.s00_axis_tready !== 1'b0) begin
               n_bad++;
               $display("FAIL early_ready: got %b want 0",
                        axis.s00_axis_tready);
            end
         end
         n_cmp++;
         if (start !== 1'b0) begin
            n_bad++;
            $display("FAIL start_in_send: got %b want 0", start);
         end
         if (pstall) begin
            n_cmp++;
            if ({axis.m00_axis_tlast, axis.m00_axis_tdata} !== {ptl, ptd}) begin
               n_bad++;
               $display("FAIL stall_hold: got %b/%h want %b/%h",
                        axis.m00_axis_tlast, axis.m00_axis_tdata, ptl, ptd);
            end
         end
         if (axis.m00_axis_tvalid && axis.m00_axis_tready) begin
            n_cmp++;
            if ({axis.m00_axis_tlast, axis.m00_axis_tdata}
                !== {(idx == SZ - 1), model[idx]}) begin
               n_bad++;
               $display("FAIL beat%0d: got %b/%h want %b/%h", idx,
                        axis.m00_axis_tlast, axis.m00_axis_tdata,
                        (idx == SZ - 1), model[idx]);
            end
            if (mode == 0) begin
               n_cmp++;
               if (cyc != idx + 1) begin
                  n_bad++;
                  $display("FAIL beat_cycle: got %0d want %0d", cyc, idx + 1);
               end
            end
            idx++;
            pstall = 1'b0;
         end else begin
            pstall = axis.m00_axis_tvalid;
            ptd    = axis.m00_axis_tdata;
            ptl    = axis.m00_axis_tlast;
         end
         @(negedge clk);
         cyc++;
      end
      go    = 1'b0;
      wr_en = 1'b0;
      axis.m00_axis_tready = 1'b0;
      n_cmp++;
      if (idx != SZ) begin
         n_bad++;
         $display("FAIL beat_count: got %0d want %0d", idx, SZ);
      end
      n_cmp++;
      if ({start, axis.m00_axis_tvalid} !== 2'b10) begin
         n_bad++;
         $display("FAIL kick: got start/tvalid=%b want 10",
                  {start, axis.m00_axis_tvalid});
      end
      if (mode == 0) begin
         n_cmp++;
         if (cyc != SZ + 1) begin
            n_bad++;
            $display("FAIL kick_cycle: got %0d want %0d", cyc, SZ + 1);
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({start, axis.s00_axis_tready, busy} !== 3'b011) begin
         n_bad++;
         $display("FAIL wait_entry: got start/rdy/busy=%b want 011",
                  {start, axis.s00_axis_tready, busy});
      end
      if (give) begin
         d = early ? 0 : int'($urandom_range(0, 4));
         repeat (d) begin
            n_cmp++;
            if ({axis.s00_axis_tready, result_valid} !== 2'b10) begin
               n_bad++;
               $display("FAIL wait_hold: got rdy/rv=%b want 10",
                        {axis.s00_axis_tready, result_valid});
            end
            @(negedge clk);
         end
         axis.s00_axis_tvalid = 1'b1;
         axis.s00_axis_tdata  = rv;
         @(negedge clk);
         axis.s00_axis_tvalid = 1'b0;
         n_cmp++;
         if ({result_valid, busy, result} !== {2'b10, rv}) begin
            n_bad++;
            $display("FAIL result: got rv/busy/res=%b%b/%h want 10/%h",
                     result_valid, busy, result, rv);
         end
         repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, result_valid, axis.m00_axis_tvalid} !== 3'b010) begin
               n_bad++;
               $display("FAIL after_result: got busy/rv/tv=%b want 010",
                        {busy, result_valid, axis.m00_axis_tvalid});
            end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      for (int i = 0; i < SZ; i++)
         write_word(4'(i), 32'(i + 1));
      run_frame(0, 32'h42DC0000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_stall;
      run_frame(1, $urandom, 1'b0, 1'b0, 1'b1);
      run_frame(2, $urandom, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_ignore_busy;
      run_frame(0, $urandom, 1'b0, 1'b1, 1'b1);
      run_frame(2, $urandom, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_oob_write;
      write_word(4'd12, $urandom);
      for (int a = 0; a < 16; a++)
         write_word(4'(a), $urandom);
      run_frame(0, $urandom, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid;
      int n;
      @(negedge clk);
      go = 1'b1;
      axis.m00_axis_tready = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n  = 0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (axis.m00_axis_tdata !== model[4]) begin
         n_bad++;
         $display("FAIL beat5_data: got %h want %h",
                  axis.m00_axis_tdata, model[4]);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      axis.m00_axis_tready = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_busy: got %b want 0", busy);
      end
      run_frame(0, $urandom, 1'b0, 1'b0, 1'b1);
   endtask

`ifdef FFT_DRV_TIMEOUT_EN
   task automatic test_timeout;
      run_frame(0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (15) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, timeout} !== 2'b10) begin
            n_bad++;
            $display("FAIL tmo_wait: got busy/to=%b want 10",
                     {busy, timeout});
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({timeout, busy, result_valid} !== 3'b100) begin
         n_bad++;
         $display("FAIL tmo_hit: got to/busy/rv=%b want 100",
                  {timeout, busy, result_valid});
      end
      run_frame(0, $urandom, 1'b0, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      go      = 1'b0;
      axis.m00_axis_tready = 1'b0;
      axis.s00_axis_tvalid = 1'b0;
      axis.s00_axis_tdata  = '0;
      axis.s00_axis_tlast  = 1'b0;
      for (int i = 0; i < SZ; i++)
         model[i] = '0;
      test_reset;
      test_basic;
      test_stall;
      test_ignore_busy;
      test_oob_write;
      test_reset_mid;
`ifdef FFT_DRV_TIMEOUT_EN
      test_timeout;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_stream_driver.md
# fft_stream_driver

Host-side driver for the stream accumulator engine, sitting on the opposite end of both of its AXI-Stream links. It holds one frame of SIZE IEEE-754 single-precision words loaded through a simple register write port. On command it streams the frame out as an AXI-Stream master with tlast, then pulses `start`. It then accepts the single result word on an AXI-Stream slave and holds it for the host.

## Interface
Parameters:
- `SIZE`, 10, words per frame; ≥2
- `DATA_WIDTH`, 32, stream and buffer word width
- `ADDR_WIDTH`, 4, buffer write-address width; 2^ADDR_WIDTH ≥ SIZE
- `TIMEOUT_CYCLES`, 1024, result wait limit (only with `FFT_DRV_TIMEOUT_EN`)

Ports (one clock; reset is asynchronous and active-low):
- `s00_axi_aclk`  in  1  clock
- `s00_axi_aresetn`  in  1  asynchronous active-low reset
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  ADDR_WIDTH  buffer write address
- `wr_data`  in  DATA_WIDTH  buffer write data
- `go`  in  1  launch one frame; single-cycle pulse
- `m00_axis_tvalid`  out  1  outgoing sample valid
- `m00_axis_tdata`  out  DATA_WIDTH  outgoing sample
- `m00_axis_tlast`  out  1  last sample of frame
- `m00_axis_tready`  in  1  engine accepts sample
- `start`  out  1  one-cycle compute trigger to engine
- `s00_axis_tvalid`  in  1  result valid from engine
- `s00_axis_tdata`  in  DATA_WIDTH  result word
- `s00_axis_tlast`  in  1  result last; captured, not checked
- `s00_axis_tready`  out  1  driver accepts result
- `result`  out  DATA_WIDTH  captured result
- `result_valid`  out  1  sticky; result holds a fresh value
- `busy`  out  1  state ≠ IDLE
- `timeout`  out  1  sticky wait-limit flag

## Operation
- States: IDLE → SEND → KICK → WAIT → IDLE.
- IDLE:
  - `wr_en` with `wr_addr` < SIZE writes `buf[wr_addr]`. Writes with `wr_addr` ≥ SIZE are dropped.
  - `go` clears `result_valid` and `timeout`, clears `rd_ptr`, and moves to SEND.
- SEND:
  - `m00_axis_tvalid`=1, `m00_axis_tdata`=`buf[rd_ptr]`, `m00_axis_tlast`=(`rd_ptr`==SIZE-1).
  - On a tvalid&&tready handshake, `rd_ptr` increments. The handshake with tlast moves to KICK.
  - tvalid, tdata and tlast stay stable while tready is low.
- KICK: `start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - `s00_axis_tready`=1. A handshake captures `s00_axis_tdata` into `result`, sets `result_valid`, and returns to IDLE.
- Outside WAIT, `s00_axis_tready`=0 and incoming results are not consumed.
- `go` while busy is ignored. `wr_en` while busy is ignored; the buffer stays frozen during a frame.
- Reset values:
  - state=IDLE, `rd_ptr`=0.
  - All stream valid/ready outputs are 0; `start`=0.
  - `result`=0, `result_valid`=0, `busy`=0, `timeout`=0.
  - `buf` is not reset; contents survive reset and are undefined after power-up.
- Reset mid-frame aborts immediately to IDLE. No partial tlast is issued.

## Timing
- `go` sampled high at edge N: `m00_axis_tvalid`=1 from cycle N+1.
- With `m00_axis_tready` held high:
  - beats occupy cycles N+1…N+SIZE;
  - `start` is high in cycle N+SIZE+1;
  - `s00_axis_tready` is high from N+SIZE+2.
- Result handshake at edge M: `result`/`result_valid` update at M. `busy` drops in cycle M+1.
- All outputs are registered or decoded from registered state. No input-to-output combinational paths other than the stream stall hold.

## Configuration
- `FFT_DRV_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle without a handshake.
  - On reaching TIMEOUT_CYCLES, `timeout` is set and the state returns to IDLE. `result` and `result_valid` stay unchanged (0 after `go`).
  - A handshake in the same cycle as the limit wins; `timeout` stays 0.
- Undefined: WAIT lasts indefinitely, `timeout` is tied 0, and no counter is built.

## Test plan
- Load buf[i]=i+1 (SIZE=10), `go`, tready held 1 → 10 beats with data 1…10, tlast only on beat 10, `start` pulse in cycle 11. Engine returns 0x42DC0000 → `result`=0x42DC0000, `result_valid`=1, `busy`=0.
- Same frame with tready toggling 1,0 → beats spread over 20 cycles; tdata/tlast stable during each stall; no duplicate or skipped words.
- `go` and `wr_en` asserted during SEND → ignored: exactly one frame sent, buffer contents unchanged on the next frame.
- Write to address 12 → ignored; buf[0..9] unchanged.
- Reset asserted on beat 5 → all outputs 0 immediately. A subsequent `go` resends the full frame from beat 1.
- With `FFT_DRV_TIMEOUT_EN`, TIMEOUT_CYCLES=16, no result → `timeout`=1 after 16 WAIT cycles, `busy`=0, `result_valid`=0. The next `go` clears `timeout`.
